// File: rtl/ag32_gbd_ip_if.sv
`timescale 1ns/1ps
// ag32_gbd_ip_if
// Cart-slot side of the Game Boy cartridge bus. The bidirectional data bus (cart_d) stays
// a plain inout port on the mapper so the tristate resolution happens on a single net.
//   cart_CLK  PHI clock from the console (1 MHz)
//   cart_a    address bus
//   cart_nCS  SRAM-area select, active low
//   cart_nRD  read strobe, active low
//   cart_nWR  write strobe, active low
// master: the console (or a bench standing in for it); slave: the mapper.
interface ag32_gbd_ip_if;
  logic        cart_CLK;
  logic [15:0] cart_a;
  logic        cart_nCS;
  logic        cart_nRD;
  logic        cart_nWR;

  modport master (output cart_CLK, cart_a, cart_nCS, cart_nRD, cart_nWR);
  modport slave  (input  cart_CLK, cart_a, cart_nCS, cart_nRD, cart_nWR);
endinterface

// File: rtl/ag32_gbd_ip.sv
`timescale 1ns/1ps
// ag32_gbd_ip
// Game Boy Camera cartridge mapper (MAC-GBD). Decodes cart bus cycles, holds ROM/RAM bank
// and camera registers, drives the external ROM/SRAM selects and high address bits, and
// sequences the M64282FP sensor through reset, register load, start and exposure.
// All cart bus inputs are asynchronous and pass through SYNC_STAGES flops on sys_clock.
//
// Ports:
//   sys_clock, resetn      fabric clock, asynchronous active-low reset
//   cart (slave modport)   cart_CLK, cart_a, cart_nCS, cart_nRD, cart_nWR
//   cart_d                 cart data bus, driven only during reads this block answers
//   cart_nRST              cart reset, low while resetn is low
//   rom_a, rom_nCS         ROM bank address [22:14] and ROM select
//   ram_a, ram_nCS,        SRAM bank address [16:13], select, CE2 and write enable
//   ram_ce2, ram_nWE
//   sens_*                 sensor clock/reset/load/serial-in/start, sens_read input
//   dbgout6, dbgout8       copy of sens_xck, synchronised cart_nWR
//
// Optional build macro GBD_BANK_ECHO_EN: ROM and SRAM-area reads are answered by this
// block with the bank registers (bring-up aid). Undefined, the external chips drive them.
module ag32_gbd_ip #(
  parameter int unsigned CAPTURE_XCK = 100,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic          sys_clock,
  input  logic          resetn,
  ag32_gbd_ip_if.slave  cart,
  inout  wire  [7:0]    cart_d,
  output logic          cart_nRST,
  output logic [22:14]  rom_a,
  output logic          rom_nCS,
  output logic [16:13]  ram_a,
  output logic          ram_nCS,
  output logic          ram_ce2,
  output logic          ram_nWE,
  output logic          sens_xck,
  output logic          sens_reset,
  output logic          sens_load,
  output logic          sens_sin,
  output logic          sens_start,
  input  logic          sens_read,
  output logic          dbgout6,
  output logic          dbgout8
);

  localparam int unsigned SyncW = 29;
  // Idle bus: strobes and select high, everything else low.
  localparam logic [SyncW-1:0] SyncRst = {1'b0, 16'h0000, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam int unsigned ExpW = $clog2(CAPTURE_XCK + 1);
  localparam logic [ExpW-1:0] ExpLast = ExpW'(CAPTURE_XCK - 1);

  typedef enum logic [2:0] {StIdle, StRst, StLoad, StStart, StExpose} cap_st_e;

  // ---------------------------------------------------------------- synchronisers
  logic [SyncW-1:0] sync_q [SYNC_STAGES];
  logic [SyncW-1:0] sync_raw;
  logic        clk_s, ncs_s, nrd_s, nwr_s, read_s;
  logic [15:0] a_s;
  logic [7:0]  d_s;

  assign sync_raw = {cart.cart_CLK, cart.cart_a, cart_d, cart.cart_nCS, cart.cart_nRD,
                     cart.cart_nWR, sens_read};

  always_ff @(posedge sys_clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= SyncRst;
    end else begin
      sync_q[0] <= sync_raw;
      for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign {clk_s, a_s, d_s, ncs_s, nrd_s, nwr_s, read_s} = sync_q[SYNC_STAGES-1];

  // sens_read is observed only; pixel data is handled elsewhere.
  logic unused_sig;
  assign unused_sig = ^{read_s, a_s[12:7]};

  // ---------------------------------------------------------------- edges, run flag
  logic clk_prev_q, nwr_prev_q, run_q;

  always_ff @(posedge sys_clock or negedge resetn) begin
    if (!resetn) begin
      clk_prev_q <= 1'b0;
      nwr_prev_q <= 1'b1;
      run_q      <= 1'b0;
    end else begin
      clk_prev_q <= clk_s;
      nwr_prev_q <= nwr_s;
      run_q      <= 1'b1;
    end
  end

  logic clk_rise, wr_commit;
  assign clk_rise  = clk_s & ~clk_prev_q;
  assign wr_commit = nwr_s & ~nwr_prev_q;

  // ---------------------------------------------------------------- decode
  logic [7:0] rom_bank_q;
  logic [3:0] ram_bank_q;
  logic       cam_sel_q;
  logic       busy_q;
  logic       ram_area, ram_sel, cam_wr, cap_start, cap_done;
  logic       xck_q, xck_fall;
  logic [6:0] load_idx;
  cap_st_e    st_q;
  logic [ExpW-1:0] exp_cnt_q;

  assign ram_area  = ~ncs_s && (a_s[15:13] == 3'b101);
  assign ram_sel   = ram_area & ~cam_sel_q;
  assign cam_wr    = wr_commit & ram_area & cam_sel_q;
  assign cap_start = cam_wr && (a_s[6:0] == 7'd0) && d_s[0] && !busy_q;
  assign xck_fall  = busy_q & clk_rise & xck_q;
  assign cap_done  = xck_fall && (st_q == StExpose) && (exp_cnt_q == ExpLast);

  always_ff @(posedge sys_clock or negedge resetn) begin
    if (!resetn) begin
      rom_bank_q <= 8'h00;
      ram_bank_q <= 4'h0;
      cam_sel_q  <= 1'b0;
    end else if (wr_commit) begin
      if (a_s[15:13] == 3'b001) begin
        rom_bank_q <= d_s;
      end else if (a_s[15:13] == 3'b010) begin
        cam_sel_q  <= d_s[4];
        ram_bank_q <= d_s[3:0];
      end
    end
  end

  // ---------------------------------------------------------------- camera registers
  logic [7:0] cam_q [128];

  always_ff @(posedge sys_clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 128; i++) cam_q[i] <= 8'h00;
    end else begin
      if (cam_wr) begin
        // The start bit cannot be changed by software while a capture runs.
        if ((a_s[6:0] == 7'd0) && busy_q) cam_q[0] <= {d_s[7:1], cam_q[0][0]};
        else                              cam_q[a_s[6:0]] <= d_s;
      end
      if (cap_done) cam_q[0][0] <= 1'b0;
    end
  end

  // ---------------------------------------------------------------- capture sequencer
  logic [2:0]  reg_idx_q;
  logic [3:0]  bit_idx_q;
  logic [10:0] sh_q;
  logic        rst_q, load_q, start_q;

  // Camera regs 1..8 feed sensor addresses 0..7; next word after reg_idx_q is reg+2.
  assign load_idx = {4'd0, reg_idx_q} + 7'd2;

  always_ff @(posedge sys_clock or negedge resetn) begin
    if (!resetn) begin
      st_q      <= StIdle;
      busy_q    <= 1'b0;
      xck_q     <= 1'b0;
      rst_q     <= 1'b0;
      load_q    <= 1'b0;
      start_q   <= 1'b0;
      sh_q      <= '0;
      reg_idx_q <= '0;
      bit_idx_q <= '0;
      exp_cnt_q <= '0;
    end else begin
      if (cap_start) busy_q <= 1'b1;

      if (!busy_q)       xck_q <= 1'b0;
      else if (clk_rise) xck_q <= ~xck_q;

      // Every state change lands on a falling sens_xck so the sensor sees stable
      // data on its rising edge.
      if (xck_fall) begin
        case (st_q)
          StIdle: begin
            st_q  <= StRst;
            rst_q <= 1'b1;
          end
          StRst: begin
            st_q      <= StLoad;
            rst_q     <= 1'b0;
            reg_idx_q <= 3'd0;
            bit_idx_q <= 4'd0;
            load_q    <= 1'b0;
            sh_q      <= {3'd0, cam_q[1]};
          end
          StLoad: begin
            if (bit_idx_q == 4'd10) begin
              load_q <= 1'b0;
              if (reg_idx_q == 3'd7) begin
                st_q    <= StStart;
                start_q <= 1'b1;
                sh_q    <= '0;
              end else begin
                reg_idx_q <= reg_idx_q + 3'd1;
                bit_idx_q <= 4'd0;
                sh_q      <= {reg_idx_q + 3'd1, cam_q[load_idx]};
              end
            end else begin
              sh_q      <= {sh_q[9:0], 1'b0};
              bit_idx_q <= bit_idx_q + 4'd1;
              load_q    <= (bit_idx_q == 4'd9);
            end
          end
          StStart: begin
            st_q      <= StExpose;
            start_q   <= 1'b0;
            exp_cnt_q <= '0;
          end
          StExpose: begin
            if (exp_cnt_q == ExpLast) begin
              st_q   <= StIdle;
              busy_q <= 1'b0;
            end else begin
              exp_cnt_q <= exp_cnt_q + 1'b1;
            end
          end
          default: st_q <= StIdle;
        endcase
      end
    end
  end

  assign sens_xck   = xck_q;
  assign sens_reset = rst_q;
  assign sens_load  = load_q;
  assign sens_sin   = sh_q[10];
  assign sens_start = start_q;

  // ---------------------------------------------------------------- read drive
  logic [7:0] dout_d, dout_q;
  logic       oe_d, oe_q;

  always_comb begin
    dout_d = 8'h00;
    oe_d   = 1'b0;
    if (!nrd_s) begin
      if (ram_area && cam_sel_q) begin
        oe_d   = 1'b1;
        dout_d = (a_s[6:0] == 7'd0) ? {7'b1110000, busy_q} : 8'h00;
      end
`ifdef GBD_BANK_ECHO_EN
      else if (!a_s[15]) begin
        oe_d   = 1'b1;
        dout_d = a_s[14] ? rom_bank_q : 8'h00;
      end else if (ram_area) begin
        oe_d   = 1'b1;
        dout_d = {4'hF, ram_bank_q};
      end
`endif
    end
  end

  always_ff @(posedge sys_clock or negedge resetn) begin
    if (!resetn) begin
      dout_q <= 8'h00;
      oe_q   <= 1'b0;
    end else begin
      dout_q <= dout_d;
      oe_q   <= oe_d;
    end
  end

  assign cart_d = oe_q ? dout_q : 8'bz;

  // ---------------------------------------------------------------- memory side
  assign rom_a     = (!a_s[15] && a_s[14]) ? {1'b0, rom_bank_q} : 9'd0;
  assign rom_nCS   = a_s[15] | nrd_s | ~nwr_s;
  assign ram_a     = ram_bank_q;
  assign ram_nCS   = ~ram_sel;
  assign ram_nWE   = ram_sel ? nwr_s : 1'b1;
  assign ram_ce2   = run_q;
  assign cart_nRST = run_q;
  assign dbgout6   = xck_q;
  assign dbgout8   = nwr_s;

endmodule

// File: tb/tb_ag32_gbd_ip.sv
`timescale 1ns/1ps
// Directed bench for ag32_gbd_ip: bank registers, SRAM decode, camera registers and a full
// sensor capture sequence, plus reset in the middle of a capture.
module tb_ag32_gbd_ip;

  logic        sys_clock;
  logic        resetn;
  wire  [7:0]  cart_d;
  logic [7:0]  tb_d;
  logic        tb_oe;
  logic        cart_nRST, rom_nCS, ram_nCS, ram_ce2, ram_nWE;
  logic [22:14] rom_a;
  logic [16:13] ram_a;
  logic        sens_xck, sens_reset, sens_load, sens_sin, sens_start, sens_read;
  logic        dbgout6, dbgout8;

  int n_vec;
  int n_miss;

  ag32_gbd_ip_if bus ();

  assign cart_d = tb_oe ? tb_d : 8'bz;

  ag32_gbd_ip dut (
    .sys_clock  (sys_clock),
    .resetn     (resetn),
    .cart       (bus),
    .cart_d     (cart_d),
    .cart_nRST  (cart_nRST),
    .rom_a      (rom_a),
    .rom_nCS    (rom_nCS),
    .ram_a      (ram_a),
    .ram_nCS    (ram_nCS),
    .ram_ce2    (ram_ce2),
    .ram_nWE    (ram_nWE),
    .sens_xck   (sens_xck),
    .sens_reset (sens_reset),
    .sens_load  (sens_load),
    .sens_sin   (sens_sin),
    .sens_start (sens_start),
    .sens_read  (sens_read),
    .dbgout6    (dbgout6),
    .dbgout8    (dbgout8)
  );

  initial sys_clock = 1'b0;
  always #5 sys_clock = ~sys_clock;

  initial bus.cart_CLK = 1'b0;
  always #500 bus.cart_CLK = ~bus.cart_CLK;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  // Bus cycle results
  logic [7:0] rd_d;
  logic       rd_romncs, rd_ramncs, wr_ramncs, wr_ramnwe;
  logic [8:0] rd_roma;
  logic [3:0] rd_rama;

  // Sensor stream record: {reset, load, start, sin} at each sens_xck rising edge
  logic [3:0] rec [256];
  int         rec_n;

  task automatic bus_write(input logic [15:0] addr, input logic [7:0] data);
    @(negedge sys_clock);
    bus.cart_a   = addr;
    bus.cart_nCS = (addr[15:13] == 3'b101) ? 1'b0 : 1'b1;
    tb_d  = data;
    tb_oe = 1'b1;
    #100;
    bus.cart_nWR = 1'b0;
    #250;
    wr_ramncs = ram_nCS;
    wr_ramnwe = ram_nWE;
    #50;
    bus.cart_nWR = 1'b1;
    #100;
    tb_oe        = 1'b0;
    bus.cart_nCS = 1'b1;
    #100;
  endtask

  task automatic bus_read(input logic [15:0] addr);
    @(negedge sys_clock);
    bus.cart_a   = addr;
    bus.cart_nCS = (addr[15:13] == 3'b101) ? 1'b0 : 1'b1;
    #100;
    bus.cart_nRD = 1'b0;
    #300;
    rd_d      = cart_d;
    rd_romncs = rom_nCS;
    rd_ramncs = ram_nCS;
    rd_roma   = rom_a;
    rd_rama   = ram_a;
    bus.cart_nRD = 1'b1;
    #100;
    bus.cart_nCS = 1'b1;
    #100;
  endtask

  task automatic test_reset();
    resetn       = 1'b0;
    tb_oe        = 1'b0;
    tb_d         = 8'h00;
    sens_read    = 1'b0;
    bus.cart_a   = 16'h0000;
    bus.cart_nCS = 1'b1;
    bus.cart_nRD = 1'b1;
    bus.cart_nWR = 1'b1;
    #200;
    @(negedge sys_clock);
    n_vec++; if (cart_nRST !== 1'b0) begin n_miss++;
      $display("FAIL rst_cart_nRST: got %b want 0", cart_nRST); end
    n_vec++; if (ram_ce2 !== 1'b0) begin n_miss++;
      $display("FAIL rst_ram_ce2: got %b want 0", ram_ce2); end
    n_vec++; if ({rom_nCS, ram_nCS, ram_nWE} !== 3'b111) begin n_miss++;
      $display("FAIL rst_selects: got %b want 111", {rom_nCS, ram_nCS, ram_nWE}); end
    n_vec++; if ({sens_xck, sens_reset, sens_load, sens_sin, sens_start} !== 5'b0) begin
      n_miss++; $display("FAIL rst_sensor: got %b want 00000",
        {sens_xck, sens_reset, sens_load, sens_sin, sens_start}); end
    n_vec++; if ({rom_a, ram_a} !== 13'd0) begin n_miss++;
      $display("FAIL rst_addr: got %h want 0000", {rom_a, ram_a}); end
    @(negedge sys_clock);
    resetn = 1'b1;
    repeat (10) @(negedge sys_clock);
    n_vec++; if ({cart_nRST, ram_ce2} !== 2'b11) begin n_miss++;
      $display("FAIL run_nRST_ce2: got %b want 11", {cart_nRST, ram_ce2}); end
    n_vec++; if ({rom_nCS, ram_nCS, ram_nWE, dbgout8} !== 4'b1111) begin n_miss++;
      $display("FAIL run_idle_selects: got %b want 1111", {rom_nCS, ram_nCS, ram_nWE, dbgout8}); end
  endtask

  task automatic test_rom_bank();
    bus_read(16'h2000);
`ifdef GBD_BANK_ECHO_EN
    n_vec++; if (rd_d !== 8'h00) begin n_miss++;
      $display("FAIL rd2000_data: got %h want 00", rd_d); end
`endif
    n_vec++; if (rd_romncs !== 1'b0) begin n_miss++;
      $display("FAIL rd2000_rom_nCS: got %b want 0", rd_romncs); end
    bus_read(16'h6000);
`ifdef GBD_BANK_ECHO_EN
    n_vec++; if (rd_d !== 8'h00) begin n_miss++;
      $display("FAIL rd6000_bank0_data: got %h want 00", rd_d); end
`endif
    n_vec++; if (rd_romncs !== 1'b0) begin n_miss++;
      $display("FAIL rd6000_rom_nCS: got %b want 0", rd_romncs); end
    bus_write(16'h2000, 8'h05);
    bus_read(16'h6000);
`ifdef GBD_BANK_ECHO_EN
    n_vec++; if (rd_d !== 8'h05) begin n_miss++;
      $display("FAIL rd6000_bank5_data: got %h want 05", rd_d); end
`endif
    n_vec++; if (rd_roma !== 9'h005) begin n_miss++;
      $display("FAIL rom_a_bank5: got %h want 005", rd_roma); end
    bus_read(16'h2000);
    n_vec++; if (rd_roma !== 9'h000) begin n_miss++;
      $display("FAIL rom_a_low_window: got %h want 000", rd_roma); end
    // Writes outside the register windows must not touch the bank.
    bus_write(16'h6000, 8'h77);
    bus_write(16'h0000, 8'h33);
    bus_read(16'h4000);
    n_vec++; if (rd_roma !== 9'h005) begin n_miss++;
      $display("FAIL ignored_writes_rom_a: got %h want 005", rd_roma); end
  endtask

  task automatic test_ram_bank();
    bus_read(16'hA010);
`ifdef GBD_BANK_ECHO_EN
    n_vec++; if (rd_d !== 8'hF0) begin n_miss++;
      $display("FAIL rdA010_bank0_data: got %h want F0", rd_d); end
`endif
    n_vec++; if ({rd_ramncs, rd_romncs} !== 2'b01) begin n_miss++;
      $display("FAIL rdA010_selects: got %b want 01", {rd_ramncs, rd_romncs}); end
    bus_write(16'h4000, 8'h01);
    bus_read(16'hA010);
`ifdef GBD_BANK_ECHO_EN
    n_vec++; if (rd_d !== 8'hF1) begin n_miss++;
      $display("FAIL rdA010_bank1_data: got %h want F1", rd_d); end
`endif
    n_vec++; if (rd_rama !== 4'h1) begin n_miss++;
      $display("FAIL ram_a_bank1: got %h want 1", rd_rama); end
    n_vec++; if (rd_ramncs !== 1'b0) begin n_miss++;
      $display("FAIL ram_nCS_bank1: got %b want 0", rd_ramncs); end
    bus_write(16'hA010, 8'h5A);
    n_vec++; if ({wr_ramncs, wr_ramnwe} !== 2'b00) begin n_miss++;
      $display("FAIL sram_write_strobes: got %b want 00", {wr_ramncs, wr_ramnwe}); end
  endtask

  task automatic test_cam_regs();
    bus_write(16'h4000, 8'h10);
    for (int i = 1; i <= 3; i++) begin
      bus_write(16'hA000 + 16'(i), 8'hA0 + 8'(i));
      n_vec++; if ({wr_ramncs, wr_ramnwe} !== 2'b11) begin n_miss++;
        $display("FAIL cam_write%0d_sram_idle: got %b want 11", i, {wr_ramncs, wr_ramnwe}); end
    end
    bus_read(16'hA010);
    n_vec++; if (rd_d !== 8'h00) begin n_miss++;
      $display("FAIL cam_rd_offset10: got %h want 00", rd_d); end
    n_vec++; if (rd_ramncs !== 1'b1) begin n_miss++;
      $display("FAIL cam_rd_ram_nCS: got %b want 1", rd_ramncs); end
    bus_read(16'hA000);
    n_vec++; if (rd_d !== 8'hE0) begin n_miss++;
      $display("FAIL cam_idle_status: got %h want E0", rd_d); end
  endtask

  task automatic test_capture();
    time         t0;
    int          guard;
    logic        xck_prev;
    logic [7:0]  regval [8];
    logic [10:0] got_sin, got_load;
    logic [10:0] exp_w;
    int          nz, highs;
    regval = '{8'hA1, 8'hA2, 8'hA3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    rec_n = 0;
    t0 = $time;
    fork
      begin
        bus_write(16'hA000, 8'h03);
        #10000;
        bus_read(16'hA000);
        n_vec++; if (rd_d !== 8'hE1) begin n_miss++;
          $display("FAIL busy_status: got %h want E1", rd_d); end
      end
      begin
        xck_prev = 1'b0;
        guard = 0;
        while (rec_n < 191 && guard < 45000) begin
          @(negedge sys_clock);
          guard++;
          if (sens_xck && !xck_prev) begin
            rec[rec_n] = {sens_reset, sens_load, sens_start, sens_sin};
            rec_n++;
          end
          xck_prev = sens_xck;
        end
      end
    join
    n_vec++; if (rec_n !== 191) begin n_miss++;
      $display("FAIL xck_periods: got %0d want 191", rec_n); end
    n_vec++; if (rec[0] !== 4'b0000) begin n_miss++;
      $display("FAIL first_period: got %b want 0000", rec[0]); end
    n_vec++; if (rec[1] !== 4'b1000) begin n_miss++;
      $display("FAIL reset_period: got %b want 1000", rec[1]); end
    for (int r = 0; r < 8; r++) begin
      for (int b = 0; b < 11; b++) begin
        got_sin[10-b]  = rec[2 + 11*r + b][0];
        got_load[10-b] = rec[2 + 11*r + b][2];
      end
      exp_w = {3'(r), regval[r]};
      n_vec++; if ({got_load, got_sin} !== {11'b00000000001, exp_w}) begin n_miss++;
        $display("FAIL load_word%0d: got load %b sin %b want load 00000000001 sin %b",
                 r, got_load, got_sin, exp_w); end
    end
    n_vec++; if (rec[90] !== 4'b0010) begin n_miss++;
      $display("FAIL start_period: got %b want 0010", rec[90]); end
    nz = 0;
    for (int i = 91; i < 191; i++) if (rec[i] !== 4'b0000) nz++;
    n_vec++; if (nz !== 0) begin n_miss++;
      $display("FAIL expose_quiet: got %0d active periods want 0", nz); end
    while ($time - t0 < 600000) @(negedge sys_clock);
    bus_read(16'hA000);
    n_vec++; if (rd_d !== 8'hE0) begin n_miss++;
      $display("FAIL done_status: got %h want E0", rd_d); end
    highs = 0;
    repeat (500) begin
      @(negedge sys_clock);
      if (sens_xck !== 1'b0) highs++;
    end
    n_vec++; if (highs !== 0) begin n_miss++;
      $display("FAIL xck_stopped: got %0d high samples want 0", highs); end
  endtask

  task automatic test_reset_mid_capture();
    int highs;
    bus_write(16'hA000, 8'h01);
    #30000;
    bus_read(16'hA000);
    n_vec++; if (rd_d !== 8'hE1) begin n_miss++;
      $display("FAIL mid_busy: got %h want E1", rd_d); end
    @(negedge sys_clock);
    resetn = 1'b0;
    #20;
    n_vec++; if ({cart_nRST, sens_xck, sens_reset, sens_load, sens_sin, sens_start} !== 6'b0)
    begin n_miss++; $display("FAIL mid_reset_outputs: got %b want 000000",
      {cart_nRST, sens_xck, sens_reset, sens_load, sens_sin, sens_start}); end
    @(negedge sys_clock);
    resetn = 1'b1;
    #200;
    bus_write(16'h4000, 8'h10);
    bus_read(16'hA000);
    n_vec++; if (rd_d !== 8'hE0) begin n_miss++;
      $display("FAIL post_reset_status: got %h want E0", rd_d); end
    highs = 0;
    repeat (300) begin
      @(negedge sys_clock);
      if (sens_xck !== 1'b0) highs++;
    end
    n_vec++; if (highs !== 0) begin n_miss++;
      $display("FAIL post_reset_xck: got %0d high samples want 0", highs); end
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    test_reset();
    test_rom_bank();
    test_ram_bank();
    test_cam_regs();
    test_capture();
    test_reset_mid_capture();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
